// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/sub unit.
// Also provides the saturation constants used when SERIAL_ADDSUB_SAT_EN is defined.
package serial_addsub_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Widest operand the saturation helpers can describe.
  localparam int SAT_MAX_W = 64;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // Bit-counter width for a given operand width (WIDTH >= 2).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  // Largest positive value, 0111..1, zero-extended to SAT_MAX_W.
  function automatic logic [SAT_MAX_W-1:0] sat_pos(input int width);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < width - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative value, 1000..0, zero-extended to SAT_MAX_W.
  function automatic logic [SAT_MAX_W-1:0] sat_neg(input int width);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i == width - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Single combinational full-adder cell shared by every bit position of the serial datapath.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, one bit per clock, LSB first.
// Optional build macro: SERIAL_ADDSUB_SAT_EN (saturate Y on signed overflow).
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             Ovrflw
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   r_sh;
  logic [WIDTH-1:0]   r_next;
  logic [WIDTH-1:0]   y_final;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               sum_bit;
  logic               carry_out;
  logic               last_bit;
  logic               ovf_now;

  serial_fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (sum_bit),
    .cout (carry_out)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign r_next   = {sum_bit, r_sh[WIDTH-1:1]};
  // On the MSB edge the flop holds the carry into the MSB; the cell gives the carry out.
  assign ovf_now  = carry ^ carry_out;
  assign busy     = (state_q == SHIFT);

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam logic [SAT_MAX_W-1:0] SAT_POS_FULL = sat_pos(WIDTH);
  localparam logic [SAT_MAX_W-1:0] SAT_NEG_FULL = sat_neg(WIDTH);
  localparam logic [WIDTH-1:0]     SAT_POS      = SAT_POS_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SAT_NEG      = SAT_NEG_FULL[WIDTH-1:0];

  // At the MSB edge a_sh[0] is the sign bit of the latched A.
  assign y_final = ovf_now ? (a_sh[0] ? SAT_NEG : SAT_POS) : r_next;
`else
  assign y_final = r_next;
`endif

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      Y      <= '0;
      Ovrflw <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B ^ {WIDTH{M}};
            carry <= M;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          r_sh  <= r_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= carry_out;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            Y      <= y_final;
            Ovrflw <= ovf_now;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH=4), aware of SERIAL_ADDSUB_SAT_EN.
module tb_serial_addsub;

  localparam int WIDTH = 4;
`ifdef SERIAL_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             m;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             ovrflw;

  int tests_run = 0;
  int tests_failed = 0;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (a),
    .B      (b),
    .M      (m),
    .busy   (busy),
    .done   (done),
    .Y      (y),
    .Ovrflw (ovrflw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: start sampled at edge 0, result expected at edge WIDTH.
  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic mv, input logic [3:0] exp_y, input logic exp_ov);
    int early;
    early = 0;
    a = av; b = bv; m = mv; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    // Scramble inputs mid-operation; the latched operands must be used.
    a = ~av; b = ~bv; m = ~mv;
    for (int e = 1; e < WIDTH; e++) begin
      tick();
      if (done) early++;
    end
    check({tag, "_early_done"}, 32'(early), 32'd0);
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_y"}, 32'(y), 32'(exp_y));
    check({tag, "_ov"}, 32'(ovrflw), 32'(exp_ov));
    check({tag, "_idle"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_y_hold"}, 32'(y), 32'(exp_y));
  endtask

  initial begin
    logic [3:0] exp3_y;
    int pulses;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; m = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_ov", 32'(ovrflw), 32'd0);
    rst_n = 1'b1;
    tick();

    // -7+6=-1; -7-6 overflows; 7+1 overflows; 0-0 has MSB carry-out but no overflow.
    run_op("t1_add", 4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0);
    run_op("t2_sub_ovf", 4'b1001, 4'b0110, 1'b1, SAT ? 4'b1000 : 4'b0011, 1'b1);
    run_op("t3_add_ovf", 4'b0111, 4'b0001, 1'b0, SAT ? 4'b0111 : 4'b1000, 1'b1);
    run_op("t4_zero_sub", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
    run_op("t_sub_pos_ovf", 4'b0111, 4'b1000, 1'b1, SAT ? 4'b0111 : 4'b1111, 1'b1);
    run_op("t_add_neg_ovf", 4'b1000, 4'b1000, 1'b0, SAT ? 4'b1000 : 4'b0000, 1'b1);
    run_op("t_add_small", 4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0);

    // start held for 12 edges: accepted at edges 0, 5 and 10 (each in the IDLE done cycle),
    // completing at edges 4, 9 and 14; operand changes in flight must not matter.
    exp3_y = SAT ? 4'b1000 : 4'b0111;
    a = 4'b0011; b = 4'b0001; m = 1'b0; start = 1'b1;
    tick();
    pulses = 0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (done) pulses++;
      if (e == 4 || e == 9 || e == 14) begin
        check($sformatf("t5_done_e%0d", e), 32'(done), 32'd1);
      end
      if (e == 4) begin
        check("t5_op1_y", 32'(y), 32'b0100);
        check("t5_op1_ov", 32'(ovrflw), 32'd0);
      end
      if (e == 9) begin
        check("t5_op2_y", 32'(y), 32'b0011);
        check("t5_op2_ov", 32'(ovrflw), 32'd0);
      end
      if (e == 14) begin
        check("t5_op3_y", 32'(y), 32'(exp3_y));
        check("t5_op3_ov", 32'(ovrflw), 32'd1);
      end
      if (e == 2)  begin a = 4'b0101; b = 4'b0010; m = 1'b1; end
      if (e == 7)  begin a = 4'b1100; b = 4'b0101; m = 1'b1; end
      if (e == 11) begin start = 1'b0; a = 4'b1111; b = 4'b1111; m = 1'b0; end
    end
    check("t5_pulse_count", 32'(pulses), 32'd3);

    // Reset sampled at edge 2 of an operation aborts it without a done pulse.
    a = 4'b0010; b = 4'b0011; m = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_y", 32'(y), 32'd0);
    check("t6_ov", 32'(ovrflw), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int e = 0; e < WIDTH + 2; e++) begin
      tick();
      if (done) pulses++;
    end
    check("t6_no_pulse", 32'(pulses), 32'd0);
    run_op("t6_after_rst", 4'b0010, 4'b0011, 1'b1, 4'b1111, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
